// File: rtl/mem_bridge.sv
// mem_bridge: memory-side responder for the control sequencer's state bus.
// Decodes memory-class state codes into MAR loads and req/ack memory
// transfers, holding the sequencer with stall until each transfer completes.
module mem_bridge #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] sp,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Sequencer state codes handled by this block; all others are ignored.
    localparam logic [7:0] STATE_FETCH_PC   = 8'h10;
    localparam logic [7:0] STATE_FETCH_SP   = 8'h11;
    localparam logic [7:0] STATE_LOAD_ADDR  = 8'h12;
    localparam logic [7:0] STATE_FETCH_INST = 8'h20;
    localparam logic [7:0] STATE_SET_REG    = 8'h21;
    localparam logic [7:0] STATE_RET        = 8'h22;
    localparam logic [7:0] STATE_SET_MEM    = 8'h30;
    localparam logic [7:0] STATE_STACK_REG  = 8'h31;
    localparam logic [7:0] STATE_STORE_PC   = 8'h32;

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_REQ,
        XF_DONE,
        XF_ERR
    } xfer_t;

    xfer_t             r_xf;
    xfer_t             w_xf_next;
    logic [7:0]        r_state_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_bus_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_entry;
    logic w_is_rd;
    logic w_is_wr;
    logic w_idle_like;
    logic w_issue;
    logic w_timeout;
    logic w_stall;

    // Classify the current state code and detect a fresh state entry.
    always_comb begin
        w_entry     = (state != r_state_q);
        w_is_rd     = (state == STATE_FETCH_INST) || (state == STATE_SET_REG) ||
                      (state == STATE_RET);
        w_is_wr     = (state == STATE_SET_MEM) || (state == STATE_STACK_REG) ||
                      (state == STATE_STORE_PC);
        w_idle_like = (r_xf == XF_IDLE) || (r_xf == XF_ERR);
        w_issue     = w_idle_like && w_entry && (w_is_rd || w_is_wr);
        w_timeout   = (r_cnt == CNT_LAST);
    end

    // Transfer FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xf <= XF_IDLE;
        end else begin
            r_xf <= w_xf_next;
        end
    end

    // Transfer FSM next state and stall; ack takes priority over timeout.
    always_comb begin
        w_xf_next = r_xf;
        w_stall   = 1'b0;
        case (r_xf)
            XF_IDLE, XF_ERR: begin
                if (w_issue) begin
                    w_xf_next = XF_REQ;
                    w_stall   = 1'b1;
                end
            end
            XF_REQ: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_xf_next = XF_DONE;
                end else if (w_timeout) begin
                    w_xf_next = XF_ERR;
                end
            end
            XF_DONE: begin
                w_xf_next = XF_IDLE;
            end
            default: begin
                w_xf_next = XF_IDLE;
            end
        endcase
    end

    // Address register, memory port registers, read capture and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= '0;
            r_cnt       <= '0;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_bus_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state_q <= state;

            if (w_idle_like && w_entry) begin
                case (state)
                    STATE_FETCH_PC:  r_mar <= pc;
                    STATE_FETCH_SP:  r_mar <= sp;
                    STATE_LOAD_ADDR: r_mar <= ADDR_W'(r_mdr);
                    default:         r_mar <= r_mar;
                endcase
            end

            if (w_issue) begin
                r_mem_addr  <= r_mar;
                r_mem_we    <= w_is_wr;
                r_mem_wdata <= wdata;
                r_mem_req   <= 1'b1;
                r_cnt       <= '0;
            end

            if (r_xf == XF_REQ) begin
                if (mem_ack) begin
                    if (!r_mem_we) begin
                        r_mdr <= mem_rdata;
                    end
                    r_mem_req <= 1'b0;
                end else if (w_timeout) begin
                    r_mem_req <= 1'b0;
                    r_bus_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign mar       = r_mar;
    assign mdr       = r_mdr;
    assign stall     = w_stall;
    assign bus_err   = r_bus_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-side responder for the CPU control sequencer's state bus.
- Watches the 8-bit control state and decodes the memory-class states into address-register loads, instruction/operand reads and data/stack writes.
- Drives a req/ack external memory port and holds the sequencer with `stall` until each transfer completes.
- Sits between the control FSM/datapath and program/data RAM.

Parameters:
- ADDR_W, 8, width of memory address and address register (MAR).
- DATA_W, 8, width of memory data, MDR and write data.
- TIMEOUT, 15, max cycles in REQ waiting for `mem_ack` before abort; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- state  input  8  control state code from the sequencer (STATE_* symbols).
- pc  input  ADDR_W  program counter value.
- sp  input  ADDR_W  stack pointer value.
- wdata  input  DATA_W  register/PC byte to be written to memory.
- mar  output  ADDR_W  memory address register.
- mdr  output  DATA_W  last byte read from memory.
- stall  output  1  hold sequencer; high while a transfer is pending.
- bus_err  output  1  sticky timeout flag.
- mem_req  output  1  external request; held until ack.
- mem_we  output  1  1 = write, 0 = read; valid while `mem_req` is high.
- mem_addr  output  ADDR_W  external address (= `mar` latched at issue).
- mem_wdata  output  DATA_W  external write data.
- mem_ack  input  1  memory completion, one-cycle pulse.
- mem_rdata  input  DATA_W  read data, valid in the `mem_ack` cycle.

Behaviour:
- Reset (synchronous): `mar`, `mdr`, `mem_addr`, `mem_wdata`, `mem_req`, `mem_we`, `bus_err` = 0; state_q = 0; FSM = IDLE.
- Entry detect: `entry = (state != state_q)`, combinational. state_q <= `state` every cycle.
  - Because the sequencer holds `state` while stalled, each state entry triggers at most one action.
- MAR-class states act on entry, in one cycle, with no stall:
  - STATE_FETCH_PC: mar <= pc.
  - STATE_FETCH_SP: mar <= sp.
  - STATE_LOAD_ADDR: mar <= mdr.
- Read-class states: STATE_FETCH_INST, STATE_SET_REG, STATE_RET.
- Write-class states: STATE_SET_MEM, STATE_STACK_REG, STATE_STORE_PC.
- Transfer FSM: IDLE, REQ, DONE, ERR.
  - IDLE: on entry of a read/write-class state:
    - mem_addr <= mar, mem_we <= write-class, mem_wdata <= wdata (captured now).
    - mem_req <= 1, counter <= 0, go REQ.
  - REQ: mem_req = 1; address, we and wdata stable. Counter increments each cycle.
    - On mem_ack: read captures mdr <= mem_rdata; mem_req <= 0; go DONE.
    - Else if counter == TIMEOUT-1: mem_req <= 0, bus_err <= 1, mdr unchanged, go ERR.
  - DONE: one cycle, then IDLE.
  - ERR: acts as IDLE for new transfers; bus_err stays 1 until reset.
- `stall` is combinational: `(FSM==IDLE|ERR & entry & read/write-class) | (FSM==REQ)`.
- Latency:
  - Trigger at cycle N; REQ at N+1.
  - Zero-wait ack at N+1 gives mdr valid and stall low from N+2. Minimum stall = 2 cycles.
  - k wait cycles add k.
- Boundaries:
  - `mem_ack` outside REQ: ignored.
  - `mem_ack` on the timeout cycle: ack wins, no error.
  - State change during REQ: ignored; the sequencer must not change state while stalled.
  - Entry of a non-memory state during DONE: no action. Entry of a memory state in DONE cannot occur, because stall released one cycle earlier.
  - Reset mid-REQ: mem_req low after the reset edge; mdr cleared; no partial capture.
  - Address width: mar holds ADDR_W bits; a pc/sp/mdr value wraps naturally, no saturation.
  - All other state codes (HALT, NEXT, ALU, MOV, JUMP, ...): no action, stall low.

Test Plan:
- Reset, state=FETCH_PC with pc=0x05, then FETCH_INST; memory acks in the first REQ cycle with 0x3C -> mar=0x05, mem_addr=0x05, mem_we=0, stall high exactly 2 cycles, mdr=0x3C.
- FETCH_SP with sp=0xF0, then STACK_REG with wdata=0xA7; ack after 3 wait cycles -> mem_we=1, mem_addr=0xF0, mem_wdata=0xA7, stall high 5 cycles, mdr unchanged.
- LOAD_ADDR after mdr=0x80 -> mar=0x80 next cycle, no stall; following SET_MEM writes to 0x80.
- Read with no ack (TIMEOUT=15) -> mem_req drops after 15 REQ cycles, bus_err=1 and sticky, stall released, next transfer still issues.
- Reset asserted during a read's 2nd REQ cycle -> mem_req=0, mdr=0, bus_err=0 next cycle. A late mem_ack after reset is ignored.
- Sequencer holds SET_REG for 4 cycles with one ack -> exactly one mem_req rising edge; spurious mem_ack while IDLE leaves mdr unchanged.
